// File: rtl/squareroot_mahsqr_k8.sv
// Hybrid approximate square root (MAHSQR, k=8) for 16-bit unsigned radicands.
// Upper 4 root bits come from an exact digit recurrence on R[15:8]. Lower 4 bits
// come from an LOD-based approximate division rem*256+R[7:0] / (32*z), with z
// rounded to the nearest power of two. When R < 256 the low byte's exact root is
// used instead.
module squareroot_mahsqr_k8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] R,
  output logic [7:0]  final_op
);

  // Restoring digit-recurrence integer square root of an 8-bit value (4 iterations)
  function automatic logic [3:0] isqrt8(input logic [7:0] x);
    logic [9:0] acc;
    logic [9:0] trial;
    logic [3:0] root;
    acc  = '0;
    root = '0;
    for (int i = 3; i >= 0; i--) begin
      acc   = {acc[7:0], x[2*i+1 -: 2]};
      trial = {4'b0000, root, 2'b01};
      if (acc >= trial) begin
        acc  = acc - trial;
        root = {root[2:0], 1'b1};
      end else begin
        root = {root[2:0], 1'b0};
      end
    end
    return root;
  endfunction

  // Debug-visible internal nodes
  logic [3:0]  quo_exact_z;
  logic [7:0]  rem;
  logic [15:0] num;
  logic [7:0]  zm;
  logic [7:0]  Y;
  logic [7:0]  y;
  logic [2:0]  mLOD;
  logic [3:0]  shamt;
  logic [15:0] shifted_num;
  logic [15:0] shifted_num_up;
  logic [7:0]  maybe_Q_0;
  logic [7:0]  maybe_Q_1;
  logic        sel_up;
  logic        z_nz;
  logic [3:0]  quo_lo;
  logic [7:0]  quo_exact_x;
  logic [7:0]  final_op_d;
  logic [7:0]  final_op_q;

  // Exact root of the upper byte, its remainder, and the fraction numerator
  always_comb begin
    quo_exact_z = isqrt8(R[15:8]);
    rem         = R[15:8] - ({4'b0000, quo_exact_z} * {4'b0000, quo_exact_z});
    num         = {rem, R[7:0]};
    zm          = {4'b0000, quo_exact_z};
    Y           = zm;
    z_nz        = (Y != 8'h00);
    quo_lo      = isqrt8(R[7:0]);
  end

  // Leading-one position of z; only meaningful when z is nonzero
  always_comb begin
    if (quo_exact_z[3])      mLOD = 3'd3;
    else if (quo_exact_z[2]) mLOD = 3'd2;
    else if (quo_exact_z[1]) mLOD = 3'd1;
    else                     mLOD = 3'd0;
  end

  // Round z up to the next power of two when the bit below the leading one is set
  always_comb begin
    sel_up = 1'b0;
    case (mLOD)
      3'd1:    sel_up = quo_exact_z[0];
      3'd2:    sel_up = quo_exact_z[1];
      3'd3:    sel_up = quo_exact_z[2];
      default: sel_up = 1'b0;
    endcase
  end

  // Shift-based division by 32*2^mLOD (or 32*2^(mLOD+1)), saturated to 8 bits
  always_comb begin
    shamt          = {1'b0, mLOD} + 4'd5;
    shifted_num    = num >> shamt;
    shifted_num_up = shifted_num >> 1;
    maybe_Q_0      = (|shifted_num[15:8])    ? 8'hFF : shifted_num[7:0];
    maybe_Q_1      = (|shifted_num_up[15:8]) ? 8'hFF : shifted_num_up[7:0];
    y              = sel_up ? maybe_Q_1 : maybe_Q_0;
  end

  // Clamp the fraction to 4 bits, or use the exact low-byte root when z is zero
  always_comb begin
    if (z_nz) begin
      quo_exact_x = (y > 8'd15) ? 8'd15 : y;
    end else begin
      quo_exact_x = {4'b0000, quo_lo};
    end
    // {z,4'b0} is zero when z is zero, so one adder covers both cases; max 255
    final_op_d = {quo_exact_z, 4'b0000} + quo_exact_x;
  end

  // Output register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) final_op_q <= 8'h00;
    else     final_op_q <= final_op_d;
  end

  assign final_op = final_op_q;

endmodule

// File: tb/tb_squareroot_mahsqr_k8.sv
// Directed bench for squareroot_mahsqr_k8 with hand-computed expected roots.
module tb_squareroot_mahsqr_k8;

  logic        clk;
  logic        rst;
  logic [15:0] R;
  logic [7:0]  final_op;

  int n_tests;
  int n_fail;

  squareroot_mahsqr_k8 dut (
    .clk      (clk),
    .rst      (rst),
    .R        (R),
    .final_op (final_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outside the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [15:0] r;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs.push_back('{"exact_0100", 16'h0100, 8'h10});
    vecs.push_back('{"exact_0400", 16'h0400, 8'h20});
    vecs.push_back('{"zero",       16'h0000, 8'h00});
    vecs.push_back('{"low_00c8",   16'h00C8, 8'h0E});
    vecs.push_back('{"low_00ff",   16'h00FF, 8'h0F});
    vecs.push_back('{"low_0001",   16'h0001, 8'h01});
    vecs.push_back('{"low_0003",   16'h0003, 8'h01});
    vecs.push_back('{"sat_0300",   16'h0300, 8'h1F});
    vecs.push_back('{"q0_8799",    16'h8799, 8'hBE});
    vecs.push_back('{"q0_0200",    16'h0200, 8'h18});
    vecs.push_back('{"q0_0500",    16'h0500, 8'h24});
    vecs.push_back('{"q0_0600",    16'h0600, 8'h28});
    vecs.push_back('{"q1_0c00",    16'h0C00, 8'h36});
    vecs.push_back('{"q1_ffff",    16'hFFFF, 8'hFF});

    // Reset with full-scale operand applied
    rst = 1'b1;
    R   = 16'hFFFF;
    step();
    step();
    check_eq("reset", final_op, 8'h00);

    rst = 1'b0;
    step();
    check_eq("first_after_reset", final_op, 8'hFF);

    foreach (vecs[i]) begin
      R = vecs[i].r;
      step();
      check_eq(vecs[i].tag, final_op, vecs[i].exp);
    end

    // Back-to-back stream, one result per edge
    R = 16'h0100;
    step();
    check_eq("b2b_0", final_op, 8'h10);
    R = 16'h8799;
    step();
    check_eq("b2b_1", final_op, 8'hBE);
    R = 16'hFFFF;
    step();
    check_eq("b2b_2", final_op, 8'hFF);

    // Mid-stream reset wins over data, then the stream resumes
    R   = 16'h8799;
    rst = 1'b1;
    step();
    check_eq("mid_reset", final_op, 8'h00);
    rst = 1'b0;
    step();
    check_eq("resume", final_op, 8'hBE);
    R = 16'h0300;
    step();
    check_eq("resume_next", final_op, 8'h1F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
